// File: rtl/bp_be_fetch_redirect_ctl.sv
// Backend end of the FE fetch/command protocol: forwards correct-path fetch packets
// through a 1-entry issue register and turns trap/mispredict events into FE redirects.
module bp_be_fetch_redirect_ctl #(
  parameter int unsigned eaddr_width_p               = 64,
  parameter int unsigned instr_width_p               = 32,
  parameter int unsigned branch_metadata_fwd_width_p = 36,
  parameter logic [eaddr_width_p-1:0] first_pc_p     = 64'h8000_0000,
  parameter int unsigned squash_timeout_p            = 64
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   fetch_v_i,
  input  logic                                   fetch_exc_i,
  input  logic [eaddr_width_p-1:0]               fetch_pc_i,
  input  logic [instr_width_p-1:0]               fetch_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] fetch_metadata_i,
  output logic                                   fetch_yumi_o,
  output logic                                   issue_v_o,
  output logic                                   issue_exc_o,
  output logic [eaddr_width_p-1:0]               issue_pc_o,
  output logic [instr_width_p-1:0]               issue_instr_o,
  output logic [branch_metadata_fwd_width_p-1:0] issue_metadata_o,
  input  logic                                   issue_ready_i,
  input  logic                                   mispredict_v_i,
  input  logic [eaddr_width_p-1:0]               mispredict_tgt_i,
  input  logic [branch_metadata_fwd_width_p-1:0] mispredict_metadata_i,
  input  logic                                   trap_v_i,
  input  logic [eaddr_width_p-1:0]               trap_pc_i,
  output logic                                   flush_o,
  output logic                                   cmd_v_o,
  output logic [eaddr_width_p-1:0]               cmd_pc_o,
  output logic [branch_metadata_fwd_width_p-1:0] cmd_metadata_o,
  input  logic                                   cmd_ready_i,
  output logic [15:0]                            drop_cnt_o
);

  localparam int unsigned CNT_W = (squash_timeout_p > 2) ? $clog2(squash_timeout_p) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(squash_timeout_p - 1);

  typedef enum logic [1:0] {S_RUN, S_CMD, S_SQUASH} state_e;

  typedef struct packed {
    logic                                   exc;
    logic [eaddr_width_p-1:0]               pc;
    logic [instr_width_p-1:0]               instr;
    logic [branch_metadata_fwd_width_p-1:0] meta;
  } pkt_t;

  state_e                                 state_q, state_d;
  logic [eaddr_width_p-1:0]               cmd_pc_q, cmd_pc_d;
  logic [branch_metadata_fwd_width_p-1:0] cmd_meta_q, cmd_meta_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic                                   issue_v_q, issue_v_d;
  pkt_t                                   issue_q, issue_d;
  logic [15:0]                            drop_q, drop_d;

  logic ev, space, match, load, drop;

  always_comb begin
    state_d      = state_q;
    cmd_pc_d     = cmd_pc_q;
    cmd_meta_d   = cmd_meta_q;
    cnt_d        = cnt_q;
    issue_v_d    = issue_v_q;
    issue_d      = issue_q;
    drop_d       = drop_q;
    fetch_yumi_o = 1'b0;
    load         = 1'b0;

    // Mispredicts only count on the correct path; a trap redirects from anywhere.
    ev    = trap_v_i | (mispredict_v_i & (state_q == S_RUN));
    space = ~issue_v_q | issue_ready_i;
    match = (fetch_pc_i == cmd_pc_q);

    unique case (state_q)
      S_RUN: begin
        fetch_yumi_o = fetch_v_i & space;
        load         = fetch_yumi_o;
      end
      S_CMD: begin
        fetch_yumi_o = fetch_v_i;
        if (cmd_ready_i) begin
          state_d = S_SQUASH;
          cnt_d   = '0;
        end
      end
      S_SQUASH: begin
        fetch_yumi_o = match ? (fetch_v_i & space) : fetch_v_i;
        load         = fetch_yumi_o & match;
        if (load) begin
          state_d = S_RUN;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_CMD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_CMD;
    endcase

    if (ev || reset_i) begin
      fetch_yumi_o = 1'b0;
      load         = 1'b0;
    end
    drop = fetch_yumi_o & ~load;

    if (load) begin
      issue_v_d = 1'b1;
      issue_d   = '{exc: fetch_exc_i, pc: fetch_pc_i, instr: fetch_instr_i, meta: fetch_metadata_i};
    end else if (issue_ready_i) begin
      issue_v_d = 1'b0;
    end

    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

    if (ev) begin
      state_d   = S_CMD;
      cnt_d     = '0;
      issue_v_d = 1'b0;
      if (trap_v_i) begin
        cmd_pc_d   = trap_pc_i;
        cmd_meta_d = '0;
      end else begin
        cmd_pc_d   = mispredict_tgt_i;
        cmd_meta_d = mispredict_metadata_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_CMD;
      cmd_pc_q   <= first_pc_p;
      cmd_meta_q <= '0;
      cnt_q      <= '0;
      issue_v_q  <= 1'b0;
      issue_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_pc_q   <= cmd_pc_d;
      cmd_meta_q <= cmd_meta_d;
      cnt_q      <= cnt_d;
      issue_v_q  <= issue_v_d;
      issue_q    <= issue_d;
      drop_q     <= drop_d;
    end
  end

  assign flush_o          = ev & ~reset_i;
  assign cmd_v_o          = (state_q == S_CMD);
  assign cmd_pc_o         = cmd_pc_q;
  assign cmd_metadata_o   = cmd_meta_q;
  assign issue_v_o        = issue_v_q;
  assign issue_exc_o      = issue_q.exc;
  assign issue_pc_o       = issue_q.pc;
  assign issue_instr_o    = issue_q.instr;
  assign issue_metadata_o = issue_q.meta;
  assign drop_cnt_o       = drop_q;

endmodule

// File: tb/tb_bp_be_fetch_redirect_ctl.sv
// Directed bench for bp_be_fetch_redirect_ctl: reset command, squash/accept, backpressure,
// mispredict/trap redirects and squash timeout re-send.
module tb_bp_be_fetch_redirect_ctl;
  localparam int EW = 64, IW = 32, MW = 36, TMO = 8;
  localparam logic [63:0] FIRST = 64'h8000_0000;

  logic clk_i = 1'b0, reset_i;
  logic fetch_v_i, fetch_exc_i, fetch_yumi_o;
  logic [EW-1:0] fetch_pc_i;
  logic [IW-1:0] fetch_instr_i;
  logic [MW-1:0] fetch_metadata_i;
  logic issue_v_o, issue_exc_o, issue_ready_i;
  logic [EW-1:0] issue_pc_o;
  logic [IW-1:0] issue_instr_o;
  logic [MW-1:0] issue_metadata_o;
  logic mispredict_v_i, trap_v_i, flush_o, cmd_v_o, cmd_ready_i;
  logic [EW-1:0] mispredict_tgt_i, trap_pc_i, cmd_pc_o;
  logic [MW-1:0] mispredict_metadata_i, cmd_metadata_o;
  logic [15:0] drop_cnt_o;

  int n_chk = 0, n_err = 0;

  bp_be_fetch_redirect_ctl #(
    .eaddr_width_p(EW), .instr_width_p(IW), .branch_metadata_fwd_width_p(MW),
    .first_pc_p(FIRST), .squash_timeout_p(TMO)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fetch_v_i(fetch_v_i), .fetch_exc_i(fetch_exc_i), .fetch_pc_i(fetch_pc_i),
    .fetch_instr_i(fetch_instr_i), .fetch_metadata_i(fetch_metadata_i),
    .fetch_yumi_o(fetch_yumi_o),
    .issue_v_o(issue_v_o), .issue_exc_o(issue_exc_o), .issue_pc_o(issue_pc_o),
    .issue_instr_o(issue_instr_o), .issue_metadata_o(issue_metadata_o),
    .issue_ready_i(issue_ready_i),
    .mispredict_v_i(mispredict_v_i), .mispredict_tgt_i(mispredict_tgt_i),
    .mispredict_metadata_i(mispredict_metadata_i),
    .trap_v_i(trap_v_i), .trap_pc_i(trap_pc_i), .flush_o(flush_o),
    .cmd_v_o(cmd_v_o), .cmd_pc_o(cmd_pc_o), .cmd_metadata_o(cmd_metadata_o),
    .cmd_ready_i(cmd_ready_i), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    fetch_v_i = 0; fetch_exc_i = 0; fetch_pc_i = '0; fetch_instr_i = '0; fetch_metadata_i = '0;
    issue_ready_i = 0; mispredict_v_i = 0; mispredict_tgt_i = '0; mispredict_metadata_i = '0;
    trap_v_i = 0; trap_pc_i = '0; cmd_ready_i = 0;
  endtask

  task automatic feed(input logic [63:0] pc, input logic [31:0] ins, input logic [35:0] md);
    fetch_v_i = 1; fetch_pc_i = pc; fetch_instr_i = ins; fetch_metadata_i = md;
  endtask

  initial begin
    idle();
    reset_i = 1; fetch_v_i = 1; trap_v_i = 1;
    #2;
    chk("rst_yumi", fetch_yumi_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_issue_v", issue_v_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    step();
    reset_i = 0; idle();

    // reset command held while FE not ready
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("boot_cmd_v", cmd_v_o, 1);
      chk("boot_cmd_pc", cmd_pc_o, FIRST);
      chk("boot_cmd_md", cmd_metadata_o, 0);
      step();
    end
    cmd_ready_i = 1; #1;
    chk("boot_cmd_v_rdy", cmd_v_o, 1);
    step(); idle(); #1;
    chk("squash_cmd_v", cmd_v_o, 0);

    // wrong-path drops then target match
    feed(64'h0, 32'h11, 36'h1); #1;
    chk("sq_drop_yumi", fetch_yumi_o, 1);
    chk("sq_drop_issue", issue_v_o, 0);
    step();
    feed(64'h4, 32'h12, 36'h2); step();
    feed(FIRST, 32'h13, 36'h33); issue_ready_i = 1; #1;
    chk("sq_match_yumi", fetch_yumi_o, 1);
    step();
    feed(FIRST + 4, 32'h17, 36'h44); #1;
    chk("acc_issue_v", issue_v_o, 1);
    chk("acc_issue_pc", issue_pc_o, FIRST);
    chk("acc_issue_instr", issue_instr_o, 32'h13);
    chk("acc_issue_md", issue_metadata_o, 36'h33);
    chk("acc_drop", drop_cnt_o, 2);
    chk("run_yumi", fetch_yumi_o, 1);
    step();

    // backpressure
    feed(FIRST + 8, 32'h1b, 36'h55); issue_ready_i = 0; #1;
    chk("bp_issue_pc", issue_pc_o, FIRST + 4);
    chk("bp_yumi", fetch_yumi_o, 0);
    step(); #1;
    chk("bp_hold_pc", issue_pc_o, FIRST + 4);
    chk("bp_hold_instr", issue_instr_o, 32'h17);
    chk("bp_hold_yumi", fetch_yumi_o, 0);
    issue_ready_i = 1; #1;
    chk("bp_rel_yumi", fetch_yumi_o, 1);
    step(); fetch_v_i = 0; #1;
    chk("bp_next_pc", issue_pc_o, FIRST + 8);

    // mispredict in RUN
    issue_ready_i = 0; feed(FIRST + 12, 32'h1f, 36'h66);
    mispredict_v_i = 1; mispredict_tgt_i = 64'h8000_0100; mispredict_metadata_i = 36'h5A; #1;
    chk("mp_flush", flush_o, 1);
    chk("mp_yumi", fetch_yumi_o, 0);
    step(); idle(); #1;
    chk("mp_flush_off", flush_o, 0);
    chk("mp_issue_clr", issue_v_o, 0);
    chk("mp_cmd_v", cmd_v_o, 1);
    chk("mp_cmd_pc", cmd_pc_o, 64'h8000_0100);
    chk("mp_cmd_md", cmd_metadata_o, 36'h5A);

    // mispredict ignored in CMD, fetched packets dropped
    mispredict_v_i = 1; mispredict_tgt_i = 64'hDEAD; feed(64'h40, 32'h0, 36'h0); #1;
    chk("cmd_mp_flush", flush_o, 0);
    chk("cmd_yumi", fetch_yumi_o, 1);
    step(); idle(); #1;
    chk("cmd_mp_pc", cmd_pc_o, 64'h8000_0100);
    chk("cmd_drop", drop_cnt_o, 3);

    // squash timeout re-sends the same command
    cmd_ready_i = 1; step(); idle();
    feed(64'h200, 32'h0, 36'h0);
    for (int i = 0; i < TMO; i++) begin
      #1;
      chk("tmo_cmd_v_low", cmd_v_o, 0);
      step();
    end
    fetch_v_i = 0; #1;
    chk("tmo_cmd_v", cmd_v_o, 1);
    chk("tmo_cmd_pc", cmd_pc_o, 64'h8000_0100);
    chk("tmo_cmd_md", cmd_metadata_o, 36'h5A);
    chk("tmo_drop", drop_cnt_o, 3 + TMO);

    // accept exception packet at target, back to RUN
    cmd_ready_i = 1; step(); idle();
    feed(64'h8000_0100, 32'h21, 36'h77); fetch_exc_i = 1; issue_ready_i = 1; #1;
    chk("exc_yumi", fetch_yumi_o, 1);
    step(); idle(); #1;
    chk("exc_issue_v", issue_v_o, 1);
    chk("exc_issue_exc", issue_exc_o, 1);
    chk("exc_issue_pc", issue_pc_o, 64'h8000_0100);
    chk("exc_issue_md", issue_metadata_o, 36'h77);

    // trap beats mispredict
    trap_v_i = 1; trap_pc_i = 64'h8000_0004;
    mispredict_v_i = 1; mispredict_tgt_i = 64'h8000_0300; mispredict_metadata_i = 36'h99; #1;
    chk("tm_flush", flush_o, 1);
    step(); idle(); #1;
    chk("tm_cmd_pc", cmd_pc_o, 64'h8000_0004);
    chk("tm_cmd_md", cmd_metadata_o, 0);
    chk("tm_issue_clr", issue_v_o, 0);

    // trap with cmd_ready stays in CMD
    trap_v_i = 1; trap_pc_i = 64'h8000_0008; cmd_ready_i = 1;
    step(); idle(); #1;
    chk("trc_cmd_v", cmd_v_o, 1);
    chk("trc_cmd_pc", cmd_pc_o, 64'h8000_0008);

    // trap during SQUASH
    cmd_ready_i = 1; step(); idle(); #1;
    chk("trs_sq", cmd_v_o, 0);
    trap_v_i = 1; trap_pc_i = 64'h8000_000C; #1;
    chk("trs_flush", flush_o, 1);
    step(); idle(); #1;
    chk("trs_cmd_v", cmd_v_o, 1);
    chk("trs_cmd_pc", cmd_pc_o, 64'h8000_000C);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bp_be_fetch_redirect_ctl.md
Name: bp_be_fetch_redirect_ctl

Overview:
Backend-side consumer of the frontend fetch queue and producer of frontend redirect commands. It is the other end of the pc_gen fetch/command protocol.
- Dequeues fetch/exception packets and forwards correct-path packets through a 1-entry issue register.
- Converts trap and branch-mispredict events into FE redirect commands.
- Discards wrong-path packets until the redirect target PC arrives.
- Re-sends the redirect command if the target PC never arrives.

Parameters:
eaddr_width_p, 64, PC width
instr_width_p, 32, instruction width
branch_metadata_fwd_width_p, 36, opaque metadata width, carried FE to BE and back
first_pc_p, 64'h8000_0000, PC of the redirect issued after reset
squash_timeout_p, 64, squash cycles without a target match before re-sending the command (≥2)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
fetch_v_i  in  1  fetch-queue head valid
fetch_exc_i  in  1  head packet is an exception message (instr field ignored)
fetch_pc_i  in  eaddr_width_p  packet PC
fetch_instr_i  in  instr_width_p  packet instruction
fetch_metadata_i  in  branch_metadata_fwd_width_p  packet branch metadata
fetch_yumi_o  out  1  dequeue head this cycle
issue_v_o  out  1  issue register valid
issue_exc_o  out  1  issued packet is an exception
issue_pc_o  out  eaddr_width_p  issued PC
issue_instr_o  out  instr_width_p  issued instruction
issue_metadata_o  out  branch_metadata_fwd_width_p  issued metadata
issue_ready_i  in  1  downstream accepts the issue register
mispredict_v_i  in  1  execute reports a mispredicted control transfer
mispredict_tgt_i  in  eaddr_width_p  correct next PC
mispredict_metadata_i  in  branch_metadata_fwd_width_p  metadata of the mispredicted instruction
trap_v_i  in  1  trap/interrupt redirect
trap_pc_i  in  eaddr_width_p  trap vector PC
flush_o  out  1  kill younger backend instructions
cmd_v_o  out  1  FE redirect command valid
cmd_pc_o  out  eaddr_width_p  redirect PC
cmd_metadata_o  out  branch_metadata_fwd_width_p  metadata for BTB update (zero for trap/reset)
cmd_ready_i  in  1  FE accepts the command
drop_cnt_o  out  16  saturating count of discarded packets

Behaviour:
- Clock clk_i; reset_i is asynchronous and active-high.
- Reset values: state=CMD; cmd_pc_r=first_pc_p; cmd_metadata_r=0; issue_v_o=0; drop_cnt_o=0; timeout counter=0.
- Outputs at reset: cmd_v_o=1 from the first cycle after reset deasserts. flush_o=0 and fetch_yumi_o=0 while reset_i=1.

Redirect event (combinational):
- Event fires on trap_v_i in any state, or on mispredict_v_i in RUN only. Mispredicts arriving in CMD or SQUASH are ignored.
- Trap has priority: cmd_pc_r<=trap_pc_i and metadata<=0. For a mispredict: cmd_pc_r<=mispredict_tgt_i and metadata<=mispredict_metadata_i.
- flush_o=1 in the event cycle.
- Issue register is cleared next cycle, overriding any load or issue_ready_i.
- fetch_yumi_o=0 in the event cycle.
- Next state is CMD; the timeout counter clears.

States:
- RUN: when the head packet can be taken, fetch_yumi_o=fetch_v_i & (~issue_v_o | issue_ready_i). The yumi loads the issue register next cycle. issue_v_o drops when issue_ready_i=1 and no load occurs. Throughput is 1 packet/cycle; latency from fetch_v_i to issue_v_o is 1 cycle.
- CMD: cmd_v_o=1, cmd_pc_o=cmd_pc_r, cmd_metadata_o=cmd_metadata_r. fetch_yumi_o=fetch_v_i, and every dequeued packet is dropped. On cmd_ready_i, go to SQUASH with the counter cleared. A trap in the same cycle as cmd_ready_i wins: stay in CMD with the new PC.
- SQUASH: cmd_v_o=0.
  - Head packet with PC ≠ cmd_pc_r: dequeued and dropped.
  - Head packet with PC = cmd_pc_r: accepted exactly as in RUN, with the same issue-register space condition; go to RUN.
  - Counter increments each SQUASH cycle without an accept. When it reaches squash_timeout_p-1, go to CMD, keeping cmd_pc_r and metadata (re-send).

Counters and widths:
- drop_cnt_o increments by 1 per dropped packet and saturates at 16'hFFFF.
- Exception packets follow the same path rules as fetch packets.
- PC compare is full eaddr_width_p equality.
- The metadata field is opaque and never modified.

Test Plan:
- Reset, then hold cmd_ready_i=0 for 3 cycles, then raise it → cmd_v_o=1 with cmd_pc_o=first_pc_p and cmd_metadata_o=0 throughout; state moves to SQUASH; cmd_v_o=0 the next cycle.
- After the reset command, feed PCs 0x0, 0x4, then first_pc_p, first_pc_p+4 → the first two are dropped (drop_cnt_o=2); issue_v_o=1 with issue_pc_o=first_pc_p one cycle after its dequeue, then first_pc_p+4 the next cycle with issue_ready_i=1.
- RUN, issue_ready_i=0 with the issue register full and fetch_v_i=1 → fetch_yumi_o=0; the issued packet is held stable until ready rises.
- RUN, mispredict_v_i with tgt=0x8000_0100 and metadata=0x5A → flush_o=1 for 1 cycle; issue_v_o=0 next cycle; cmd_pc_o=0x8000_0100 and cmd_metadata_o=0x5A.
- Same cycle trap_v_i (pc=0x8000_0004) and mispredict_v_i → command carries 0x8000_0004 with metadata 0. A trap during SQUASH → returns to CMD with the new PC.
- SQUASH with only non-matching PCs for squash_timeout_p cycles → cmd_v_o reasserts with the same PC and metadata.
